// File: rtl/conv_if.sv
// Column input bus and convolution result for the 3x3 correlator.
// Carries one 3-row column per cycle plus the mode select and qualifier.
interface conv_if #(
  parameter int BIT_LEN   = 8,
  parameter int CONV_LPOS = 13
);
  logic signed [BIT_LEN-1:0]   i_dato0;
  logic signed [BIT_LEN-1:0]   i_dato1;
  logic signed [BIT_LEN-1:0]   i_dato2;
  logic                        i_selecK_I;
  logic                        i_valid;
  logic signed [CONV_LPOS-1:0] o_data;

  modport master (
    output i_dato0, i_dato1, i_dato2, i_selecK_I, i_valid,
    input  o_data
  );

  modport slave (
    input  i_dato0, i_dato1, i_dato2, i_selecK_I, i_valid,
    output o_data
  );
endinterface

// File: rtl/conv.sv
// 3x3 correlator: shifts columns into a Q1.7 kernel or an unsigned pixel window and
// registers the scaled sum of products; output lags an accepted column by one edge.
module conv #(
  parameter int BIT_LEN   = 8,
  parameter int CONV_LEN  = 20,
  parameter int CONV_LPOS = 13,
  parameter int M_LEN     = 3
) (
  input logic    CLK100MHZ,
  input logic    i_reset,
  conv_if.slave  bus
);

  logic signed [BIT_LEN-1:0]   k [M_LEN][M_LEN];
  logic        [BIT_LEN-1:0]   w [M_LEN][M_LEN];
  logic        [BIT_LEN-1:0]   col [M_LEN];
  logic signed [CONV_LEN-1:0]  acc;
  logic signed [CONV_LPOS-1:0] o_q;

  always_comb begin
    col[0] = bus.i_dato0;
    col[1] = bus.i_dato1;
    col[2] = bus.i_dato2;
  end

  // Coefficient is sign-extended, pixel zero-extended, so the product is exact.
  function automatic logic signed [CONV_LEN-1:0] mac_term(
    input logic signed [BIT_LEN-1:0] coef,
    input logic        [BIT_LEN-1:0] pix
  );
    logic signed [CONV_LEN-1:0] cx;
    logic signed [CONV_LEN-1:0] px;
    cx = {{(CONV_LEN-BIT_LEN){coef[BIT_LEN-1]}}, coef};
    px = {{(CONV_LEN-BIT_LEN){1'b0}}, pix};
    return cx * px;
  endfunction

  always_comb begin
    acc = '0;
    for (int c = 0; c < M_LEN; c++) begin
      for (int r = 0; r < M_LEN; r++) begin
        acc = acc + mac_term(k[c][r], w[c][r]);
      end
    end
  end

  always_ff @(posedge CLK100MHZ or posedge i_reset) begin
    if (i_reset) begin
      for (int c = 0; c < M_LEN; c++) begin
        for (int r = 0; r < M_LEN; r++) begin
          k[c][r] <= '0;
          w[c][r] <= '0;
        end
      end
      o_q <= '0;
    end else begin
      o_q <= acc[CONV_LEN-1 -: CONV_LPOS];
      if (bus.i_valid) begin
        // Column 0 is the oldest; the new column always lands in the last slot.
        for (int c = 0; c < M_LEN-1; c++) begin
          for (int r = 0; r < M_LEN; r++) begin
            if (bus.i_selecK_I) w[c][r] <= w[c+1][r];
            else                k[c][r] <= k[c+1][r];
          end
        end
        for (int r = 0; r < M_LEN; r++) begin
          if (bus.i_selecK_I) w[M_LEN-1][r] <= col[r];
          else                k[M_LEN-1][r] <= col[r];
        end
      end
    end
  end

  assign bus.o_data = o_q;

endmodule

// File: tb/tb_conv.sv
// Directed bench for conv: stimulus queues expected o_data per edge, a negedge monitor compares.
module tb_conv;
  localparam int BIT_LEN   = 8;
  localparam int CONV_LEN  = 20;
  localparam int CONV_LPOS = 13;
  localparam int M_LEN     = 3;

  logic clk = 1'b0;
  logic rst;

  conv_if #(.BIT_LEN(BIT_LEN), .CONV_LPOS(CONV_LPOS)) bus ();

  conv #(
    .BIT_LEN(BIT_LEN), .CONV_LEN(CONV_LEN), .CONV_LPOS(CONV_LPOS), .M_LEN(M_LEN)
  ) dut (
    .CLK100MHZ(clk),
    .i_reset  (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int due;
    int val;
  } exp_t;

  exp_t  exp_q [$];
  string name_q[$];
  exp_t  cur;
  string cur_name;

  task automatic check(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: o_data=%0d expected %0d", nm, got, want);
    end
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= edges) begin
      cur      = exp_q.pop_front();
      cur_name = name_q.pop_front();
      if (cur.due != edges) check({cur_name, "_slot"}, edges, cur.due);
      else                  check(cur_name, int'(bus.o_data), cur.val);
    end
  end

  task automatic drive(input logic sel, input logic vld, input int a, input int b, input int c);
    bus.i_selecK_I = sel;
    bus.i_valid    = vld;
    bus.i_dato0    = 8'(a);
    bus.i_dato1    = 8'(b);
    bus.i_dato2    = 8'(c);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_next(input string nm, input int v);
    exp_q.push_back('{due: edges + 1, val: v});
    name_q.push_back(nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.i_selecK_I = 1'b0;
    bus.i_valid    = 1'b1;
    bus.i_dato0    = 8'h7f;
    bus.i_dato1    = 8'h7f;
    bus.i_dato2    = 8'h7f;
    #2;
    check("reset_async_start", int'(bus.o_data), 0);
    @(posedge clk);
    #1;
    check("reset_held_inputs_ignored", int'(bus.o_data), 0);
    rst = 1'b0;

    // Center tap kernel, then three image columns.
    drive(1'b0, 1'b1, 0, 0, 0);
    drive(1'b0, 1'b1, 0, 8'h40, 0);
    drive(1'b0, 1'b1, 0, 0, 0);
    drive(1'b1, 1'b1, 10, 20, 30);  expect_next("center_col1", 0);
    drive(1'b1, 1'b1, 40, 50, 60);  expect_next("center_col2", 10);
    drive(1'b1, 1'b1, 70, 80, 90);  expect_next("center_col3", 25);

    // Stall with changing inputs and mode toggling: nothing may move.
    for (int i = 0; i < 5; i++) begin
      drive(1'(i % 2), 1'b0, 11 * i + 3, 200 - i, 99);
      expect_next("stall_hold", 25);
    end
    drive(1'b1, 1'b1, 100, 110, 120); expect_next("resume_col1", 40);
    drive(1'b1, 1'b1, 1, 2, 3);       expect_next("resume_col2", 55);

    // Kernel all 0x10 computed live against the current window, then pixels all 255.
    drive(1'b0, 1'b1, 8'h10, 8'h10, 8'h10);
    drive(1'b0, 1'b1, 8'h10, 8'h10, 8'h10);
    drive(1'b0, 1'b1, 8'h10, 8'h10, 8'h10); expect_next("kernel_mode_live", 72);
    drive(1'b1, 1'b1, 255, 255, 255);
    drive(1'b1, 1'b1, 255, 255, 255);
    drive(1'b1, 1'b1, 255, 255, 255);       expect_next("positive_sum", 286);

    // Kernel all -1.0 against full-scale pixels.
    drive(1'b0, 1'b1, 8'h80, 8'h80, 8'h80);
    drive(1'b0, 1'b1, 8'h80, 8'h80, 8'h80);
    drive(1'b0, 1'b1, 8'h80, 8'h80, 8'h80); expect_next("negative_full_scale", -2295);
    drive(1'b1, 1'b1, 0, 0, 0);             expect_next("negative_partial", -1530);

    // Single -1/128 tap: small negative sums must floor, not round toward zero.
    drive(1'b0, 1'b1, 0, 0, 0);
    drive(1'b0, 1'b1, 0, 0, 0);
    drive(1'b0, 1'b1, 8'hff, 0, 0);         expect_next("single_tap_zero", 0);
    drive(1'b1, 1'b1, 5, 0, 0);             expect_next("floor_minus5", -1);
    drive(1'b1, 1'b1, 200, 9, 9);           expect_next("floor_minus200", -2);
    drive(1'b1, 1'b0, 0, 0, 0);

    // Asynchronous reset pulse between edges, mid-stream.
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("reset_async_midstream", int'(bus.o_data), 0);
    rst = 1'b0;
    drive(1'b1, 1'b1, 200, 200, 200);       expect_next("post_reset_col1", 0);
    drive(1'b1, 1'b1, 200, 200, 200);       expect_next("post_reset_col2", 0);
    drive(1'b1, 1'b1, 200, 200, 200);       expect_next("post_reset_col3", 0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) drive(1'b1, 1'b0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      cur      = exp_q.pop_front();
      cur_name = name_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: never sampled, expected %0d", cur_name, cur.val);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/conv.md
CONV -- requirements
Module: conv

Interface
REQ-001 Parameter BIT_LEN, default 8, width of each input sample and kernel coefficient.
REQ-002 Parameter CONV_LEN, default 20, width of the internal signed accumulator.
REQ-003 Parameter CONV_LPOS, default 13, width of o_data.
REQ-004 Parameter M_LEN, default 3, kernel/window dimension (3x3); only 3 is required to be supported.
REQ-005 CLK100MHZ  input  1  single clock; all state changes on its rising edge.
REQ-006 i_reset  input  1  reset, asynchronous, active-high.
REQ-007 i_dato0, i_dato1, i_dato2  input  BIT_LEN each, signed  one column of 3 values, rows 0, 1 and 2.
REQ-008 i_selecK_I  input  1  0 = kernel-load mode, 1 = image mode.
REQ-009 i_valid  input  1  qualifies the current input column.
REQ-010 o_data  output  CONV_LPOS, signed  convolution result.

Function
REQ-011 The block SHALL hold a 3x3 kernel register K[c][r] and a 3x3 pixel window W[c][r], where c = column 0 (oldest) to 2 (newest) and r = row.
REQ-012 On a clock edge with i_valid=1 and i_selecK_I=0, the kernel SHALL shift: K[0]<=K[1], K[1]<=K[2], K[2]<={i_dato0,i_dato1,i_dato2}; W is unchanged.
REQ-013 On a clock edge with i_valid=1 and i_selecK_I=1, W SHALL shift in the same way with the input column; K is unchanged.
REQ-014 On a clock edge with i_valid=0, K and W SHALL hold regardless of i_selecK_I.
REQ-015 Kernel coefficients SHALL be signed two's-complement Q1.7 (0x80 = -1.0, 0x40 = 0.5); pixels SHALL be unsigned 0..255, zero-extended before multiplication.
REQ-016 acc SHALL be sum over c,r of K[c][r]*W[c][r] (correlation order, no kernel flip), computed exactly in CONV_LEN-bit signed; the worst case |acc| = 293760 cannot overflow.
REQ-017 On every clock edge, o_data SHALL be set to acc[CONV_LEN-1 : CONV_LEN-CONV_LPOS] (arithmetic shift right by 7, truncation toward -inf, no saturation), using the K/W contents present before that edge.
REQ-018 Latency SHALL be: a column accepted at edge N is reflected in o_data after edge N+1; o_data SHALL be stable while i_valid=0.
REQ-019 The first meaningful image output SHALL appear after edge N+1, where N is the edge that accepts the third image column; earlier outputs contain zeros/stale columns and are not flagged.
REQ-020 A switch of i_selecK_I SHALL NOT clear K or W; the window persists across mode changes.
REQ-021 o_data SHALL be continuously computed in kernel-load mode as well; no output-valid strobe exists.

Reset
REQ-022 While i_reset=1, K, W and o_data SHALL be 0 immediately, without waiting for a clock edge, and inputs SHALL be ignored.
REQ-023 After i_reset deasserts, the first edge SHALL operate normally; reset mid-stream SHALL discard all partial windows and the kernel.

Verification
REQ-024 Reset: assert i_reset with no clock edge -> o_data = 0 immediately; K = W = 0.
REQ-025 Center tap: load kernel columns (0,0,0), (0,0x40,0), (0,0,0), then image columns (10,20,30), (40,50,60), (70,80,90) with valid held high -> o_data = 25 one cycle after the third image column.
REQ-026 Positive sum: kernel all 0x10, pixels all 255, three image columns -> acc = 36720 and o_data = 286.
REQ-027 Negative/full scale: kernel all 0x80, pixels all 255 -> acc = -293760 and o_data = -2295 (0x1709).
REQ-028 Stall: drop i_valid for 5 cycles mid-stream with changing inputs -> o_data and the window are unchanged; resume -> the stream continues with no lost or extra column.
REQ-029 Async reset mid-stream: pulse i_reset between clock edges -> o_data goes to 0 at once; then 3 new image columns with the kernel not reloaded -> o_data = 0.
